adc_avg_capture: RTL and testbench

ADC_AVG_CAPTURE -- requirements
Module: adc_avg_capture

---
 rtl/adc_avg_capture.sv | 93 +++++++++
 tb/tb_adc_avg_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_capture.sv
// Windowed ADC averager: accumulates 2^AVG_LOG2 samples, publishes the mean unless frozen.
// Optional clip_flag output is enabled by defining ADC_CLIP_FLAG_EN.
module adc_avg_capture #(
  parameter int DATA_W   = 14,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              freeze,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
`ifdef ADC_CLIP_FLAG_EN
  output logic              clip_flag,
`endif
  output logic [7:0]        drop_cnt
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  // A zero-width counter is not legal, so AVG_LOG2=0 keeps one bit pinned at 0.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] avg;
  logic              win_done;
  logic              publish;
  logic              drop;

  assign sum      = acc + ACC_W'(adc_data);
  assign avg      = sum[ACC_W-1:AVG_LOG2];
  assign win_done = adc_valid && (cnt == CNT_LAST);
  assign publish  = win_done && !freeze;
  assign drop     = win_done && freeze;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (adc_valid) begin
      if (win_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port  <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= publish;
      if (publish) begin
        out_port <= avg;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef ADC_CLIP_FLAG_EN
  logic clip_acc;
  logic clip_any;
  logic is_rail;

  assign is_rail  = (adc_data == '0) || (adc_data == '1);
  assign clip_any = clip_acc | is_rail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_acc  <= 1'b0;
      clip_flag <= 1'b0;
    end else begin
      if (adc_valid) begin
        clip_acc <= win_done ? 1'b0 : clip_any;
      end
      if (publish) begin
        clip_flag <= clip_any;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_avg_capture.sv
// Self-checking bench: two instances (AVG_LOG2=2 and 0) share stimulus and are
// compared every cycle against a window-sum/divide reference model.
module tb_adc_avg_capture;

  localparam int DW  = 14;
  localparam int MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          freeze = 1'b0;

  logic [DW-1:0] out_port4, out_port1;
  logic          out_valid4, out_valid1;
  logic [7:0]    drop_cnt4, drop_cnt1;
`ifdef ADC_CLIP_FLAG_EN
  logic          clip_flag4, clip_flag1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state, index 0 = 4-sample window, 1 = pass-through
  int unsigned w_sum [2];
  int          w_n   [2];
  bit          w_clip[2];
  int unsigned m_out [2];
  bit          m_vld [2];
  int          m_drop[2];
  bit          m_clip[2];

  always #5 clk = ~clk;

  adc_avg_capture #(.DATA_W(DW), .AVG_LOG2(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .freeze(freeze), .out_port(out_port4), .out_valid(out_valid4),
`ifdef ADC_CLIP_FLAG_EN
    .clip_flag(clip_flag4),
`endif
    .drop_cnt(drop_cnt4)
  );

  adc_avg_capture #(.DATA_W(DW), .AVG_LOG2(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .freeze(freeze), .out_port(out_port1), .out_valid(out_valid1),
`ifdef ADC_CLIP_FLAG_EN
    .clip_flag(clip_flag1),
`endif
    .drop_cnt(drop_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      w_sum[k] = 0; w_n[k] = 0; w_clip[k] = 0;
      m_out[k] = 0; m_vld[k] = 0; m_drop[k] = 0; m_clip[k] = 0;
    end
  endtask

  task automatic check_all();
    check("out4",  out_port4,  m_out[0]);
    check("vld4",  out_valid4, m_vld[0]);
    check("drop4", drop_cnt4,  m_drop[0]);
    check("out1",  out_port1,  m_out[1]);
    check("vld1",  out_valid1, m_vld[1]);
    check("drop1", drop_cnt1,  m_drop[1]);
`ifdef ADC_CLIP_FLAG_EN
    check("clip4", clip_flag4, m_clip[0]);
    check("clip1", clip_flag1, m_clip[1]);
`endif
  endtask

  task automatic apply_reset();
    adc_valid = 1'b0; adc_data = '0; freeze = 1'b0;
    reset_n = 1'b0;
    #2;
    model_clear();
    check_all();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic step(input bit v, input int unsigned d, input bit f);
    int n;
    adc_valid = v; adc_data = DW'(d); freeze = f;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 1;
      m_vld[k] = 0;
      if (v) begin
        w_sum[k] += d;
        w_n[k]++;
        if (d == 0 || d == MAX) w_clip[k] = 1;
        if (w_n[k] == n) begin
          if (!f) begin
            m_out[k] = w_sum[k] / n;
            m_vld[k] = 1;
            m_clip[k] = w_clip[k];
          end else if (m_drop[k] < 255) begin
            m_drop[k]++;
          end
          w_sum[k] = 0; w_n[k] = 0; w_clip[k] = 0;
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned d;
    #1;
    apply_reset();

    for (int i = 0; i < 4; i++) step(1, 100 + i, 0);
    check("req27_out", out_port4, 101);
    check("req27_vld", out_valid4, 1);
    check("req27_drop", drop_cnt4, 0);
    step(0, 0, 0);
    check("req27_pulse", out_valid4, 0);

    for (int i = 0; i < 4; i++) begin
      step(1, MAX, 0);
      repeat (3) step(0, 0, 0);
    end
    check("req28_out", out_port4, MAX);

    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 20, 0);
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, MAX), 1);
    check("req29_hold", out_port4, 20);
    check("req29_drop", drop_cnt4, 2);
    for (int i = 0; i < 4; i++) step(1, 8, 0);
    check("req29_out", out_port4, 8);

    step(1, 1000, 0);
    step(1, 3000, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 40, 0);
    check("req30_out", out_port4, 40);

    step(1, 5, 0);
    check("req31_a", out_port1, 5);
    step(1, 6, 0);
    check("req31_b", out_port1, 6);
    check("req31_vld", out_valid1, 1);
    step(1, 7, 0);
    check("req31_c", out_port1, 7);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = MAX;
        default: d = $urandom_range(0, MAX);
      endcase
      step($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 1200; i++) step(1, $urandom_range(0, MAX), 1);
    check("req32_sat", drop_cnt4, 255);
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, MAX), 1);
    check("req32_hold", drop_cnt4, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
